write_back_sequencer: RTL
=========================

// Module: write_back_sequencer
// PURPOSE
//  Sequences the write-back of processed edge-map pixels to external memory over AHB-Lite.
//  Owns the write offset counter for the output frame.
//  Accepts one 8-bit pixel per handshake and packs them into 32-bit words.
//  Issues single non-burst writes: full words (offset += 4), then 1-3 trailing byte writes (offset += 1).
//  Sits between the edge-detection datapath output and the shared AHB master port.
// PARAMETERS
//  ADDR_W   32  address/offset width; frame byte count = length*width, truncated to ADDR_W
//  DIM_W    16  width of length/width inputs
// PORTS
//  HCLK       in   1       clock; all logic on rising edge
//  HRESET     in   1       asynchronous, active-high reset
//  start      in   1       1-cycle pulse: latch base_addr/length/width, begin frame (ignored while busy)
//  base_addr  in   ADDR_W  frame base address; bits [1:0] forced to 0 when latched
//  length     in   DIM_W   frame rows
//  width      in   DIM_W   frame columns
//  pix_valid  in   1       pixel available
//  pix_data   in   8       pixel byte
//  pix_ready  out  1       pixel accepted when pix_valid & pix_ready
//  HADDR      out  ADDR_W  base + offset during address phase
//  HTRANS     out  2       2'b10 NONSEQ during address phase, else 2'b00 IDLE
//  HWRITE     out  1       1 during address phase, else 0
//  HSIZE      out  3       3'b010 word / 3'b000 byte; 0 when idle
//  HWDATA     out  32      write data during data phase
//  HREADY     in   1       slave ready; phase completes on rising edge with HREADY=1
//  HRESP      in   1       1 = error response in data phase
//  busy       out  1       high from cycle after accepted start until DONE/ABORT exit
//  done       out  1       1-cycle pulse: frame fully written
//  err        out  1       1-cycle pulse: frame aborted on HRESP
// BEHAVIOUR
//  Reset: state=IDLE; offset=0; byte count=0; pack register=0; all outputs 0 (HTRANS=IDLE).
//  Latched: total = length*width; offset tracks bytes written; remaining = total - offset.
//  States: IDLE, COLLECT, ADDR, DATA, DONE, ABORT.
//   IDLE: start -> COLLECT; offset:=0; count:=0. If total==0 -> DONE instead.
//   COLLECT: need = (remaining>=4) ? 4 : 1; pix_ready = (count<need).
//     Each handshake stores pix_data in byte lane [count] (little-endian); count++.
//     count==need -> ADDR on the next edge. No pixels are accepted outside COLLECT.
//   ADDR: HTRANS=NONSEQ, HWRITE=1, HADDR=base+offset, HSIZE per need.
//     Held stable while HREADY=0; HREADY=1 -> DATA.
//   DATA: HTRANS=IDLE; HWDATA = pack word (word write) or {4{byte}} (byte write).
//     Held while HREADY=0.
//     HREADY=1 & HRESP=0: offset += need; count:=0.
//       If remaining after the update is 0 -> DONE, else -> COLLECT.
//     HREADY=1 & HRESP=1 -> ABORT.
//   DONE: done=1 for one cycle -> IDLE.
//   ABORT: err=1 for one cycle -> IDLE; offset and count cleared.
//  Transfers are strictly non-overlapped: the next address phase starts at least 1 cycle after the data phase completes.
//  Minimum cycles per full word: 4 COLLECT + 1 ADDR + 1 DATA with zero wait states.
//  Offset and total arithmetic are ADDR_W-bit unsigned; the last address is base + total - 1.
//  start during busy: ignored, with no effect on latched values.
//  pix_valid held with no room: stalls upstream; nothing is dropped.
//  HRESET mid-frame: immediate return to reset values; the partial frame is discarded.
// TESTING
//  2x2, base 0x1000, pixels 11,22,33,44 -> one NONSEQ: HADDR=0x1000, HSIZE=2, HWDATA=0x44332211; done 1 cycle after DATA.
//  3x3, base 0x2003, pixels 01..09 -> words at 0x2000 (0x04030201) and 0x2004 (0x08070605); byte at 0x2008, HSIZE=0, HWDATA=0x09090909; then done.
//  2x2 with HREADY=0 for 3 cycles in ADDR and 2 cycles in DATA -> HADDR/HTRANS/HWDATA stable throughout; one transfer; done.
//  length=0, width=5; start -> done the cycle after IDLE exit; HTRANS never NONSEQ; pix_ready stays 0.
//  HRESP=1 with HREADY=1 on the first DATA -> err pulse; busy drops; next start restarts at offset 0.
//  HRESET asserted during ADDR -> HTRANS=0, busy=0, pix_ready=0 the same cycle; restart writes from base.

Source files
------------

// File: rtl/write_back_sequencer.sv
// Write-back sequencer: packs 8-bit edge-map pixels into words and writes the frame
// to memory as single non-burst AHB-Lite transfers, with trailing byte writes at the end.
module write_back_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  length,
    input  logic [DIM_W-1:0]  width,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [31:0]       HWDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_ADDR, S_DATA, S_DONE, S_ABORT
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q, total_q, offset_q;
    logic [ADDR_W-1:0] total_in, remaining, remaining_after;
    logic [2*DIM_W-1:0] product;
    logic [2:0]        count_q, count_nxt, need;
    logic [31:0]       pack_q;
    logic              accept, xfer_ok;

    assign product         = {{DIM_W{1'b0}}, length} * {{DIM_W{1'b0}}, width};
    assign total_in        = ADDR_W'(product);
    assign remaining       = total_q - offset_q;
    assign need            = (remaining >= ADDR_W'(4)) ? 3'd4 : 3'd1;
    assign remaining_after = remaining - ADDR_W'(need);
    assign accept          = (state == S_COLLECT) && pix_valid && pix_ready;
    assign count_nxt       = accept ? count_q + 3'd1 : count_q;
    assign xfer_ok         = (state == S_DATA) && HREADY && !HRESP;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // process sees the pre-edge values regardless of evaluation order.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = (total_in == '0) ? S_DONE : S_COLLECT;
            S_COLLECT: if (count_nxt == need) state_nxt = S_ADDR;
            S_ADDR:    if (HREADY) state_nxt = S_DATA;
            S_DATA: begin
                if (HREADY) begin
                    if (HRESP)                     state_nxt = S_ABORT;
                    else if (remaining_after == '0) state_nxt = S_DONE;
                    else                           state_nxt = S_COLLECT;
                end
            end
            S_DONE:    state_nxt = S_IDLE;
            S_ABORT:   state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            base_q   <= '0;
            total_q  <= '0;
            offset_q <= '0;
            count_q  <= '0;
            pack_q   <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                base_q   <= {base_addr[ADDR_W-1:2], 2'b00};
                total_q  <= total_in;
                offset_q <= '0;
                count_q  <= '0;
            end
            if (accept) begin
                pack_q[8*count_q[1:0] +: 8] <= pix_data;
                count_q <= count_nxt;
            end
            if (xfer_ok) begin
                offset_q <= offset_q + ADDR_W'(need);
                count_q  <= '0;
            end
            if (state == S_ABORT) begin
                offset_q <= '0;
                count_q  <= '0;
            end
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        pix_ready = 1'b0;
        HADDR     = '0;
        HTRANS    = 2'b00;
        HWRITE    = 1'b0;
        HSIZE     = 3'b000;
        HWDATA    = '0;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        err       = (state == S_ABORT);
        case (state)
            S_COLLECT: pix_ready = (count_q < need);
            S_ADDR: begin
                HTRANS = 2'b10;
                HWRITE = 1'b1;
                HADDR  = base_q + offset_q;
                HSIZE  = (need == 3'd4) ? 3'b010 : 3'b000;
            end
            S_DATA:    HWDATA = (need == 3'd4) ? pack_q : {4{pack_q[7:0]}};
            default: ;
        endcase
    end

endmodule
